// File: rtl/mem_responder.sv
// Single-outstanding memory responder: valid/ready request, WAIT_CYCLES wait states, word read / byte-strobed write.
// Optional address fault checking is enabled by defining MEM_RESPONDER_ERR_EN.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter              INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned   AW    = $clog2(DEPTH_WORDS);
  localparam int unsigned   CW    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] WLOAD = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_wcnt;

  logic          r_write;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_wstrb;
  logic [31:0]   r_rdata;
  logic          r_err;

  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_accept;
  logic          w_access;
  logic          w_handshake;
  logic          w_acc_write;
  logic [31:0]   w_acc_addr;
  logic [31:0]   w_acc_wdata;
  logic [3:0]    w_acc_wstrb;
  logic [AW-1:0] w_idx;
  logic          w_fault;
  logic          w_unused_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    w_accept  = 1'b0;
    w_access  = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_access = 1'b1;
            w_next   = RESP;
          end else begin
            w_next   = WAIT;
          end
        end
      end
      WAIT: begin
        if (r_wcnt == '0) begin
          w_access = 1'b1;
          w_next   = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_handshake = rsp_valid & rsp_ready;

  // Zero-wait accesses happen on the accepting edge, before the request registers are loaded.
  assign w_acc_write = (r_state == IDLE) ? req_write : r_write;
  assign w_acc_addr  = (r_state == IDLE) ? req_addr  : r_addr;
  assign w_acc_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
  assign w_acc_wstrb = (r_state == IDLE) ? req_wstrb : r_wstrb;
  assign w_idx       = w_acc_addr[AW+1:2];

`ifdef MEM_RESPONDER_ERR_EN
  assign w_fault = (w_acc_addr[1:0] != 2'b00) || ((w_acc_addr >> (AW + 2)) != 32'd0);
`else
  assign w_fault = 1'b0;
`endif
  assign w_unused_addr = ^{w_acc_addr[1:0], w_acc_addr >> (AW + 2)};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wcnt  <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_wstrb <= req_wstrb;
        r_wcnt  <= WLOAD;
      end else if ((r_state == WAIT) && (r_wcnt != '0)) begin
        r_wcnt  <= r_wcnt - 1'b1;
      end

      if (w_access) begin
        r_err   <= w_fault;
        r_rdata <= (w_acc_write || w_fault) ? '0 : r_mem[w_idx];
      end else if (w_handshake) begin
        r_err   <= 1'b0;
        r_rdata <= '0;
      end
    end
  end

  // The RAM has no reset; the rst gate keeps an access from committing while reset is held.
  always_ff @(posedge clk) begin
    if (w_access && !rst && w_acc_write && !w_fault) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_acc_wstrb[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
        end
      end
    end
  end

  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a WAIT_CYCLES=2 instance (u_a) and a zero-wait instance (u_b).
module tb_mem_responder;

    localparam int unsigned DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;

    logic        a_req_valid, a_req_ready, a_req_write, a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
    logic [3:0]  a_req_wstrb;

    logic        b_req_valid, b_req_ready, b_req_write, b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
    logic [3:0]  b_req_wstrb;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) u_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_wstrb(a_req_wstrb),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
    );

    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wstrb(b_req_wstrb),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One transaction on u_a; rsp_ready is held low for 'hold' cycles after rsp_valid rises.
    task automatic a_txn(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb, input int hold,
                         input logic [31:0] exp_rdata, input logic exp_err);
        int cyc;
        check({tag, "_req_ready_pre"}, a_req_ready, 1);
        a_req_valid = 1'b1;
        a_req_write = wr;
        a_req_addr  = addr;
        a_req_wdata = wdata;
        a_req_wstrb = strb;
        a_rsp_ready = 1'b0;
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        a_req_write = ~wr;
        a_req_addr  = 32'h0000_0008;
        a_req_wdata = 32'hBAD0_BAD0;
        a_req_wstrb = 4'hF;
        cyc = 0;
        while (a_rsp_valid !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 2);
        check({tag, "_rdata"}, a_rsp_rdata, exp_rdata);
        check({tag, "_err"}, a_rsp_err, exp_err);
        check({tag, "_req_ready_busy"}, a_req_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, a_rsp_valid, 1);
            check({tag, "_hold_rdata"}, a_rsp_rdata, exp_rdata);
            check({tag, "_hold_err"}, a_rsp_err, exp_err);
            check({tag, "_hold_req_ready"}, a_req_ready, 0);
        end
        a_rsp_ready = 1'b1;
        @(posedge clk); #1;
        a_rsp_ready = 1'b0;
        a_req_write = 1'b0;
        check({tag, "_post_valid"}, a_rsp_valid, 0);
        check({tag, "_post_req_ready"}, a_req_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] b_addr [2];
        logic [31:0] b_data [2];
        b_addr[0] = 32'h0000_0000; b_data[0] = 32'h1111_1111;
        b_addr[1] = 32'h0000_0004; b_data[1] = 32'h2222_2222;

        rst = 1'b1;
        a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_req_wstrb = '0; a_rsp_ready = 1'b0;
        b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_wstrb = '0; b_rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", a_req_ready, 1);
        check("rst_rsp_valid", a_rsp_valid, 0);
        check("rst_rsp_rdata", a_rsp_rdata, 0);
        check("rst_rsp_err", a_rsp_err, 0);
        check("rst_b_req_ready", b_req_ready, 1);
        rst = 1'b0;
        @(posedge clk); #1;

        a_txn("wr_full", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 1'b0);
        a_txn("rd_full", 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'hDEAD_BEEF, 1'b0);
        a_txn("wr_byte1", 1'b1, 32'h10, 32'h0000_AA00, 4'b0010, 0, 32'h0, 1'b0);
        a_txn("rd_byte1", 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'hDEAD_AAEF, 1'b0);
        a_txn("wr_nostrb", 1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, 0, 32'h0, 1'b0);
        a_txn("rd_hold", 1'b0, 32'h10, 32'h0, 4'h0, 5, 32'hDEAD_AAEF, 1'b0);

        a_txn("wr_word0", 1'b1, 32'h0, 32'h0102_0304, 4'hF, 0, 32'h0, 1'b0);
`ifdef MEM_RESPONDER_ERR_EN
        a_txn("rd_misalign", 1'b0, 32'h13, 32'h0, 4'h0, 0, 32'h0, 1'b1);
        a_txn("wr_oob", 1'b1, DEPTH * 4, 32'hFFFF_FFFF, 4'hF, 0, 32'h0, 1'b1);
        a_txn("rd_word0", 1'b0, 32'h0, 32'h0, 4'h0, 0, 32'h0102_0304, 1'b0);
`else
        a_txn("rd_misalign", 1'b0, 32'h13, 32'h0, 4'h0, 0, 32'hDEAD_AAEF, 1'b0);
        a_txn("wr_wrap", 1'b1, DEPTH * 4, 32'hFFFF_FFFF, 4'hF, 0, 32'h0, 1'b0);
        a_txn("rd_word0", 1'b0, 32'h0, 32'h0, 4'h0, 0, 32'hFFFF_FFFF, 1'b0);
`endif

        // Reset during WAIT must drop the pending write.
        a_txn("wr_commit", 1'b1, 32'h20, 32'h1234_5678, 4'hF, 0, 32'h0, 1'b0);
        a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 32'h20; a_req_wdata = 32'hCAFE_F00D; a_req_wstrb = 4'hF;
        @(posedge clk); #1;
        a_req_valid = 1'b0; a_req_write = 1'b0;
        check("wait_rsp_valid", a_rsp_valid, 0);
        check("wait_req_ready", a_req_ready, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_req_ready", a_req_ready, 1);
        check("midrst_rsp_valid", a_rsp_valid, 0);
        check("midrst_rsp_rdata", a_rsp_rdata, 0);
        check("midrst_rsp_err", a_rsp_err, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        a_txn("rd_after_rst", 1'b0, 32'h20, 32'h0, 4'h0, 0, 32'h1234_5678, 1'b0);

        // Reset during RESP drops the response.
        a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 32'h20;
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("resp_pre_rst_valid", a_rsp_valid, 1);
        rst = 1'b1;
        #1;
        check("resp_rst_valid", a_rsp_valid, 0);
        check("resp_rst_rdata", a_rsp_rdata, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Zero-wait instance: writes, then back-to-back reads with rsp_ready high.
        b_rsp_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = b_addr[i]; b_req_wdata = b_data[i]; b_req_wstrb = 4'hF;
            @(posedge clk); #1;
            b_req_valid = 1'b0; b_req_write = 1'b0;
            check("b_wr_valid", b_rsp_valid, 1);
            check("b_wr_rdata", b_rsp_rdata, 0);
            @(posedge clk); #1;
            check("b_wr_done", b_rsp_valid, 0);
        end
        b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = b_addr[0];
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("b_rd_valid", b_rsp_valid, 1);
            check("b_rd_rdata", b_rsp_rdata, b_data[i]);
            check("b_rd_req_ready", b_req_ready, 0);
            b_req_addr = b_addr[1];
            @(posedge clk); #1;
            check("b_rd_gap_valid", b_rsp_valid, 0);
            check("b_rd_gap_req_ready", b_req_ready, 1);
        end
        b_req_valid = 1'b0;
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
